bullet_pool: RTL and testbench



---
 rtl/bullet_pool.sv | 161 ++++++++++++++++
 tb/tb_bullet_pool.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bullet_pool.sv
// Pool of NUM_BULLETS independent projectile slots for the player sprite.
// Each slot latches its direction at launch, flies SPEED px/frame and retires on an edge or hit.
module bullet_pool #(
    parameter int NUM_BULLETS = 4,
    parameter int X_W         = 10,
    parameter int SPEED       = 16,
    parameter int X_MIN       = 0,
    parameter int X_MAX       = 637,
    parameter int OFFSET_X    = 15,
    parameter int OFFSET_Y    = 15,
    parameter int COOLDOWN    = 8
) (
    input  logic                       frame_clk,
    input  logic                       Reset_n,
    input  logic                       fire,
    input  logic                       m_isright,
    input  logic                       m_isleft,
    input  logic [X_W-1:0]             player_x,
    input  logic [X_W-1:0]             player_y,
    input  logic [NUM_BULLETS-1:0]     hit,
    output logic [NUM_BULLETS*X_W-1:0] bullet_x,
    output logic [NUM_BULLETS*X_W-1:0] bullet_y,
    output logic [NUM_BULLETS-1:0]     bullet_active,
    output logic                       fire_ack,
    output logic                       pool_full
);

    localparam int IDX_W = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1;
    localparam int CD_W  = $clog2(COOLDOWN + 1);
    localparam logic [X_W:0]   RIGHT_LIM = (X_W+1)'(X_MAX);
    localparam logic [X_W:0]   LEFT_LIM  = (X_W+1)'(X_MIN + SPEED);
    localparam logic [X_W:0]   STEP_EXT  = (X_W+1)'(SPEED);
    localparam logic [X_W-1:0] STEP      = X_W'(SPEED);

    typedef enum logic {
        IDLE = 1'b0,
        FLY  = 1'b1
    } slot_state_e;

    slot_state_e            state_r     [NUM_BULLETS];
    slot_state_e            state_nxt_s [NUM_BULLETS];
    logic [X_W-1:0]         x_r         [NUM_BULLETS];
    logic [X_W-1:0]         x_nxt_s     [NUM_BULLETS];
    logic [X_W-1:0]         y_r         [NUM_BULLETS];
    logic [X_W-1:0]         y_nxt_s     [NUM_BULLETS];
    logic [NUM_BULLETS-1:0] dir_r;
    logic [NUM_BULLETS-1:0] dir_nxt_s;
    logic [NUM_BULLETS-1:0] active_s;
    logic [NUM_BULLETS-1:0] retire_s;
    logic [CD_W-1:0]        cd_r;
    logic [CD_W-1:0]        cd_nxt_s;
    logic [IDX_W-1:0]       free_idx_s;
    logic                   launch_s;
    logic                   fire_ack_r;
    logic [X_W-1:0]         spawn_x_s;
    logic [X_W-1:0]         spawn_y_s;

    assign spawn_x_s     = player_x + X_W'(OFFSET_X);
    assign spawn_y_s     = player_y + X_W'(OFFSET_Y);
    assign bullet_active = active_s;
    assign pool_full     = &active_s;
    assign fire_ack      = fire_ack_r;
    assign launch_s      = fire & (cd_r == {CD_W{1'b0}}) & ~(&active_s) & (m_isright | m_isleft);

    // Unpack slot registers onto the flat buses; edge tests widened so x never wraps.
    always_comb begin
        bullet_x = '0;
        bullet_y = '0;
        active_s = '0;
        retire_s = '0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            bullet_x[i*X_W +: X_W] = x_r[i];
            bullet_y[i*X_W +: X_W] = y_r[i];
            active_s[i]            = (state_r[i] == FLY);
            retire_s[i]            = dir_r[i] ? (({1'b0, x_r[i]} + STEP_EXT) > RIGHT_LIM)
                                              : ({1'b0, x_r[i]} < LEFT_LIM);
        end
    end

    // Lowest-index idle slot, taken from the pre-edge active vector.
    always_comb begin
        free_idx_s = '0;
        for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
            free_idx_s = active_s[i] ? free_idx_s : IDX_W'(i);
        end
    end

    // Per-slot next state: idle slots park at spawn, flying slots move, hit or edge retires.
    always_comb begin
        for (int i = 0; i < NUM_BULLETS; i++) begin
            state_nxt_s[i] = state_r[i];
            dir_nxt_s[i]   = dir_r[i];
            x_nxt_s[i]     = x_r[i];
            y_nxt_s[i]     = y_r[i];
            case (state_r[i])
                FLY: begin
                    if (hit[i] || retire_s[i]) begin
                        state_nxt_s[i] = IDLE;
                        x_nxt_s[i]     = spawn_x_s;
                        y_nxt_s[i]     = spawn_y_s;
                    end else if (dir_r[i]) begin
                        x_nxt_s[i] = x_r[i] + STEP;
                    end else begin
                        x_nxt_s[i] = x_r[i] - STEP;
                    end
                end
                IDLE: begin
                    x_nxt_s[i] = spawn_x_s;
                    y_nxt_s[i] = spawn_y_s;
                    if (launch_s && (free_idx_s == IDX_W'(i))) begin
                        state_nxt_s[i] = FLY;
                        dir_nxt_s[i]   = m_isright;
                    end else begin
                        state_nxt_s[i] = IDLE;
                    end
                end
                default: begin
                    state_nxt_s[i] = IDLE;
                    x_nxt_s[i]     = spawn_x_s;
                    y_nxt_s[i]     = spawn_y_s;
                end
            endcase
        end
    end

    // Cooldown loads on launch and otherwise counts down to zero.
    always_comb begin
        cd_nxt_s = cd_r;
        if (launch_s) begin
            cd_nxt_s = CD_W'(COOLDOWN - 1);
        end else if (cd_r != {CD_W{1'b0}}) begin
            cd_nxt_s = cd_r - CD_W'(1);
        end else begin
            cd_nxt_s = cd_r;
        end
    end

    // State register; reset kills every bullet immediately.
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NUM_BULLETS; i++) begin
                state_r[i] <= IDLE;
                x_r[i]     <= '0;
                y_r[i]     <= '0;
            end
            dir_r      <= '1;
            cd_r       <= '0;
            fire_ack_r <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_BULLETS; i++) begin
                state_r[i] <= state_nxt_s[i];
                x_r[i]     <= x_nxt_s[i];
                y_r[i]     <= y_nxt_s[i];
            end
            dir_r      <= dir_nxt_s;
            cd_r       <= cd_nxt_s;
            fire_ack_r <= launch_s;
        end
    end

endmodule

// File: tb/tb_bullet_pool.sv
// Scoreboard bench for bullet_pool: expectations are queued as stimulus is driven
// and compared once the frame edge has produced the DUT outputs.
module tb_bullet_pool;

    logic        clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        fire = 1'b0;
    logic        m_isright = 1'b0;
    logic        m_isleft = 1'b0;
    logic [9:0]  player_x = 10'd0;
    logic [9:0]  player_y = 10'd0;
    logic [3:0]  hit = 4'd0;
    logic [39:0] bullet_x;
    logic [39:0] bullet_y;
    logic [3:0]  bullet_active;
    logic        fire_ack;
    logic        pool_full;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        logic [3:0] act;
        logic       ack;
        logic       full;
        int         slot;
        logic [9:0] x;
    } exp_t;

    exp_t sb[$];

    bullet_pool dut (
        .frame_clk    (clk),
        .Reset_n      (Reset_n),
        .fire         (fire),
        .m_isright    (m_isright),
        .m_isleft     (m_isleft),
        .player_x     (player_x),
        .player_y     (player_y),
        .hit          (hit),
        .bullet_x     (bullet_x),
        .bullet_y     (bullet_y),
        .bullet_active(bullet_active),
        .fire_ack     (fire_ack),
        .pool_full    (pool_full)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [9:0] dut_x(int i);
        return bullet_x[i*10 +: 10];
    endfunction

    function automatic logic [9:0] dut_y(int i);
        return bullet_y[i*10 +: 10];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        Reset_n = 1'b0;
        fire = 1'b0;
        hit = 4'd0;
        m_isright = 1'b0;
        m_isleft = 1'b0;
        #2;
        Reset_n = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e;
        #2;
        e = '{name: "reset", act: 4'b0000, ack: 1'b0, full: 1'b0, slot: 0, x: 10'd0};
        sb.push_back(e);
        e = sb.pop_front();
        checks++; if (bullet_active !== e.act) begin errors++; $display("FAIL %s active: got %b want %b", e.name, bullet_active, e.act); end
        checks++; if (fire_ack !== e.ack) begin errors++; $display("FAIL %s ack: got %b want %b", e.name, fire_ack, e.ack); end
        checks++; if (pool_full !== e.full) begin errors++; $display("FAIL %s full: got %b want %b", e.name, pool_full, e.full); end
        checks++; if (bullet_x !== 40'd0 || bullet_y !== 40'd0) begin errors++; $display("FAIL %s xy: got %h/%h want 0", e.name, bullet_x, bullet_y); end
        Reset_n = 1'b1;
    endtask

    task automatic test_launch_right();
        exp_t e;
        do_reset();
        player_x = 10'd100; player_y = 10'd200; m_isright = 1'b1; fire = 1'b1;
        for (int n = 0; n <= 33; n++) begin
            e.name = "right_flight"; e.slot = 0; e.full = 1'b0; e.ack = (n == 0);
            if (115 + 16*n <= 637) begin e.act = 4'b0001; e.x = 10'(115 + 16*n); end
            else begin e.act = 4'b0000; e.x = 10'd115; end
            sb.push_back(e);
            tick();
            if (n == 0) fire = 1'b0;
            e = sb.pop_front();
            checks++; if (bullet_active !== e.act) begin errors++; $display("FAIL %s[%0d] active: got %b want %b", e.name, n, bullet_active, e.act); end
            checks++; if (fire_ack !== e.ack) begin errors++; $display("FAIL %s[%0d] ack: got %b want %b", e.name, n, fire_ack, e.ack); end
            checks++; if (pool_full !== e.full) begin errors++; $display("FAIL %s[%0d] full: got %b want %b", e.name, n, pool_full, e.full); end
            checks++; if (dut_x(e.slot) !== e.x) begin errors++; $display("FAIL %s[%0d] x: got %0d want %0d", e.name, n, dut_x(e.slot), e.x); end
            if (n == 0 || n == 5) begin
                checks++; if (dut_y(0) !== 10'd215) begin errors++; $display("FAIL %s[%0d] y: got %0d want 215", e.name, n, dut_y(0)); end
            end
        end
    endtask

    task automatic test_launch_left();
        exp_t e;
        do_reset();
        player_x = 10'd50; player_y = 10'd200; fire = 1'b1;
        // facing neither way: no launch, no cooldown load
        for (int n = 0; n < 2; n++) begin
            e = '{name: "no_facing", act: 4'b0000, ack: 1'b0, full: 1'b0, slot: 0, x: 10'd65};
            sb.push_back(e);
            tick();
            e = sb.pop_front();
            checks++; if (bullet_active !== e.act) begin errors++; $display("FAIL %s active: got %b want %b", e.name, bullet_active, e.act); end
            checks++; if (fire_ack !== e.ack) begin errors++; $display("FAIL %s ack: got %b want %b", e.name, fire_ack, e.ack); end
        end
        m_isleft = 1'b1;
        for (int n = 0; n <= 5; n++) begin
            e.name = "left_flight"; e.slot = 0; e.full = 1'b0; e.ack = (n == 0);
            if (n < 5) begin e.act = 4'b0001; e.x = 10'(65 - 16*n); end
            else begin e.act = 4'b0000; e.x = 10'd65; end
            sb.push_back(e);
            tick();
            if (n == 0) fire = 1'b0;
            e = sb.pop_front();
            checks++; if (bullet_active !== e.act) begin errors++; $display("FAIL %s[%0d] active: got %b want %b", e.name, n, bullet_active, e.act); end
            checks++; if (fire_ack !== e.ack) begin errors++; $display("FAIL %s[%0d] ack: got %b want %b", e.name, n, fire_ack, e.ack); end
            checks++; if (dut_x(e.slot) !== e.x) begin errors++; $display("FAIL %s[%0d] x: got %0d want %0d", e.name, n, dut_x(e.slot), e.x); end
        end
    endtask

    task automatic test_autorepeat();
        exp_t e;
        do_reset();
        player_x = 10'd100; player_y = 10'd200; m_isright = 1'b1; fire = 1'b1;
        for (int n = 0; n <= 34; n++) begin
            e.name = "autorepeat"; e.slot = 0;
            e.ack = (n == 0 || n == 8 || n == 16 || n == 24 || n == 34);
            for (int k = 0; k < 4; k++) e.act[k] = (n >= 8*k && n <= 8*k + 32) || (k == 0 && n >= 34);
            e.full = &e.act;
            e.x = (n <= 32) ? 10'(115 + 16*n) : 10'd115;
            sb.push_back(e);
            tick();
            e = sb.pop_front();
            checks++; if (bullet_active !== e.act) begin errors++; $display("FAIL %s[%0d] active: got %b want %b", e.name, n, bullet_active, e.act); end
            checks++; if (fire_ack !== e.ack) begin errors++; $display("FAIL %s[%0d] ack: got %b want %b", e.name, n, fire_ack, e.ack); end
            checks++; if (pool_full !== e.full) begin errors++; $display("FAIL %s[%0d] full: got %b want %b", e.name, n, pool_full, e.full); end
            checks++; if (dut_x(e.slot) !== e.x) begin errors++; $display("FAIL %s[%0d] x: got %0d want %0d", e.name, n, dut_x(e.slot), e.x); end
        end
        fire = 1'b0;
    endtask

    task automatic test_independent_dir();
        exp_t e;
        do_reset();
        player_x = 10'd100; player_y = 10'd200; m_isright = 1'b1; fire = 1'b1;
        for (int n = 0; n <= 12; n++) begin
            e.name = "dir_slot0"; e.slot = 0; e.full = 1'b0;
            e.ack = (n == 0 || n == 8);
            e.act = (n < 8) ? 4'b0001 : 4'b0011;
            e.x = 10'(115 + 16*n);
            sb.push_back(e);
            if (n >= 8) begin
                e.name = "dir_slot1"; e.slot = 1; e.x = 10'(115 - 16*(n - 8));
                sb.push_back(e);
            end
            tick();
            if (n == 0) begin m_isright = 1'b0; m_isleft = 1'b1; end
            while (sb.size() > 0) begin
                e = sb.pop_front();
                checks++; if (bullet_active !== e.act) begin errors++; $display("FAIL %s[%0d] active: got %b want %b", e.name, n, bullet_active, e.act); end
                checks++; if (fire_ack !== e.ack) begin errors++; $display("FAIL %s[%0d] ack: got %b want %b", e.name, n, fire_ack, e.ack); end
                checks++; if (dut_x(e.slot) !== e.x) begin errors++; $display("FAIL %s[%0d] x: got %0d want %0d", e.name, n, dut_x(e.slot), e.x); end
            end
        end
        fire = 1'b0;
    endtask

    task automatic test_hit_and_reset();
        exp_t e;
        do_reset();
        player_x = 10'd100; player_y = 10'd200; m_isright = 1'b1; fire = 1'b1;
        for (int n = 0; n <= 32; n++) begin
            hit = (n == 24 || n == 25) ? 4'b0010 : 4'b0000;
            if (n == 24) begin
                e = '{name: "hit_slot3", act: 4'b1101, ack: 1'b1, full: 1'b0, slot: 3, x: 10'd115};
                sb.push_back(e);
                e = '{name: "hit_slot1_parked", act: 4'b1101, ack: 1'b1, full: 1'b0, slot: 1, x: 10'd115};
                sb.push_back(e);
            end else if (n == 25) begin
                e = '{name: "hit_idle_ignored", act: 4'b1101, ack: 1'b0, full: 1'b0, slot: 0, x: 10'd515};
                sb.push_back(e);
            end else if (n == 32) begin
                e = '{name: "reuse_slot1", act: 4'b1111, ack: 1'b1, full: 1'b1, slot: 1, x: 10'd115};
                sb.push_back(e);
            end
            tick();
            while (sb.size() > 0) begin
                e = sb.pop_front();
                checks++; if (bullet_active !== e.act) begin errors++; $display("FAIL %s active: got %b want %b", e.name, bullet_active, e.act); end
                checks++; if (fire_ack !== e.ack) begin errors++; $display("FAIL %s ack: got %b want %b", e.name, fire_ack, e.ack); end
                checks++; if (pool_full !== e.full) begin errors++; $display("FAIL %s full: got %b want %b", e.name, pool_full, e.full); end
                checks++; if (dut_x(e.slot) !== e.x) begin errors++; $display("FAIL %s x: got %0d want %0d", e.name, dut_x(e.slot), e.x); end
            end
        end
        hit = 4'b0000;
        // asynchronous reset mid-flight, no clock edge in between
        Reset_n = 1'b0;
        e = '{name: "async_reset", act: 4'b0000, ack: 1'b0, full: 1'b0, slot: 0, x: 10'd0};
        sb.push_back(e);
        #1;
        e = sb.pop_front();
        checks++; if (bullet_active !== e.act) begin errors++; $display("FAIL %s active: got %b want %b", e.name, bullet_active, e.act); end
        checks++; if (fire_ack !== e.ack) begin errors++; $display("FAIL %s ack: got %b want %b", e.name, fire_ack, e.ack); end
        checks++; if (pool_full !== e.full) begin errors++; $display("FAIL %s full: got %b want %b", e.name, pool_full, e.full); end
        checks++; if (dut_x(e.slot) !== e.x) begin errors++; $display("FAIL %s x: got %0d want %0d", e.name, dut_x(e.slot), e.x); end
        fire = 1'b0;
        Reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_launch_right();
        test_launch_left();
        test_autorepeat();
        test_independent_dir();
        test_hit_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
